// File: rtl/string_assembler_pkg.sv
// Shared constants and state encoding for the string assembler and length finder.
package string_assembler_pkg;

  localparam int unsigned STR_BYTES = 8;
  localparam int unsigned STR_W     = 64;
  localparam int unsigned LEN_W     = 4;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

endpackage

// File: rtl/string_assembler.sv
// Packs a byte stream into a fixed 8-byte string, closed by terminator, full count or flush.
// The packed-string port is named str because string is a reserved word.
module string_assembler
  import string_assembler_pkg::*;
#(
  parameter logic [7:0] TERM_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [STR_W-1:0] str,
  output logic             str_valid,
  input  logic             str_ready,
  output logic [LEN_W-1:0] byte_count
);

  state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StFill;
      str        <= '0;
      byte_count <= '0;
    end else begin
      unique case (state)
        StFill: begin
          if (in_valid) begin
            if (in_byte == TERM_BYTE) begin
              state <= StHold;
            end else begin
              // Byte-lane decode: lane i is written while byte_count == i.
              for (int unsigned i = 0; i < STR_BYTES; i++) begin
                if (byte_count == LEN_W'(i)) begin
                  str[STR_W-1-8*i -: 8] <= in_byte;
                end
              end
              byte_count <= byte_count + LEN_W'(1);
              if (byte_count == LEN_W'(STR_BYTES - 1) || flush) begin
                state <= StHold;
              end
            end
          end else if (flush && byte_count != '0) begin
            state <= StHold;
          end
        end
        StHold: begin
          if (str_ready) begin
            state      <= StFill;
            str        <= '0;
            byte_count <= '0;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

  assign in_ready  = (state == StFill);
  assign str_valid = (state == StHold);

endmodule

// File: tb/tb_string_assembler.sv
// Directed self-checking bench for string_assembler.
module tb_string_assembler;
  import string_assembler_pkg::*;

  logic             clk;
  logic             rst;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [STR_W-1:0] str;
  logic             str_valid;
  logic             str_ready;
  logic [LEN_W-1:0] byte_count;

  int errors;
  int checks;

  string_assembler #(.TERM_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .str        (str),
    .str_valid  (str_valid),
    .str_ready  (str_ready),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_hold();
    str_ready = 1'b1;
    tick();
    str_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (str !== 64'h0) begin
      errors++; $display("FAIL reset_str: got %h expected %h", str, 64'h0);
    end
    checks++;
    if (byte_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", byte_count);
    end
    checks++;
    if (str_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b ready=%b expected valid=0 ready=1",
               str_valid, in_ready);
    end
    #10;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_terminator();
    logic [7:0] seq [8];
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hAA, 8'h00};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_byte  = seq[i];
      tick();
      if (i == 6) begin
        checks++;
        if (str_valid !== 1'b0) begin
          errors++; $display("FAIL term_early_valid: got %b expected 0", str_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (str_valid !== 1'b1) begin
      errors++; $display("FAIL term_valid: got %b expected 1", str_valid);
    end
    checks++;
    if (str !== 64'hAABBCCDDEEFFAA00) begin
      errors++; $display("FAIL term_str: got %h expected %h", str, 64'hAABBCCDDEEFFAA00);
    end
    checks++;
    if (byte_count !== 4'd7) begin
      errors++; $display("FAIL term_count: got %0d expected 7", byte_count);
    end
    release_hold();
    checks++;
    if (in_ready !== 1'b1 || str !== 64'h0 || byte_count !== 4'd0) begin
      errors++;
      $display("FAIL term_release: got ready=%b str=%h count=%0d expected ready=1 str=0 count=0",
               in_ready, str, byte_count);
    end
  endtask

  task automatic test_full();
    logic [7:0] seq [8];
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hAA, 8'h99};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_byte  = seq[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || str_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_flags: got ready=%b valid=%b expected ready=0 valid=1",
               in_ready, str_valid);
    end
    checks++;
    if (str !== 64'hAABBCCDDEEFFAA99) begin
      errors++; $display("FAIL full_str: got %h expected %h", str, 64'hAABBCCDDEEFFAA99);
    end
    checks++;
    if (byte_count !== 4'd8) begin
      errors++; $display("FAIL full_count: got %0d expected 8", byte_count);
    end
    release_hold();
  endtask

  task automatic test_first_terminator();
    in_valid = 1'b1;
    in_byte  = 8'h00;
    tick();
    in_valid = 1'b0;
    checks++;
    if (str_valid !== 1'b1 || str !== 64'h0 || byte_count !== 4'd0) begin
      errors++;
      $display("FAIL first_term: got valid=%b str=%h count=%0d expected valid=1 str=0 count=0",
               str_valid, str, byte_count);
    end
    release_hold();
  endtask

  task automatic test_flush();
    logic [7:0] seq [3];
    seq = '{8'h44, 8'hBB, 8'hCC};
    str_ready = 1'b1;  // must be ignored while filling
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_byte  = seq[i];
      tick();
    end
    in_valid  = 1'b0;
    str_ready = 1'b0;
    checks++;
    if (byte_count !== 4'd3 || str_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefill: got count=%0d valid=%b expected count=3 valid=0",
               byte_count, str_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (str_valid !== 1'b1 || str !== 64'h44BBCC0000000000 || byte_count !== 4'd3) begin
      errors++;
      $display("FAIL flush_close: got valid=%b str=%h count=%0d expected valid=1 str=%h count=3",
               str_valid, str, byte_count, 64'h44BBCC0000000000);
    end
    release_hold();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (str_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got valid=%b ready=%b expected valid=0 ready=1",
               str_valid, in_ready);
    end
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (str_valid !== 1'b1 || str !== 64'h5A00000000000000 || byte_count !== 4'd1) begin
      errors++;
      $display("FAIL flush_with_accept: got valid=%b str=%h count=%0d expected valid=1 str=%h count=1",
               str_valid, str, byte_count, 64'h5A00000000000000);
    end
    release_hold();
  endtask

  task automatic test_hold();
    in_valid = 1'b1;
    in_byte  = 8'h12;
    tick();
    in_byte  = 8'h00;
    tick();
    in_byte  = 8'h55;
    flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (str_valid !== 1'b1 || str !== 64'h1200000000000000 || byte_count !== 4'd1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b str=%h count=%0d expected valid=1 str=%h count=1",
                 i, str_valid, str, byte_count, 64'h1200000000000000);
      end
    end
    flush     = 1'b0;
    str_ready = 1'b1;
    tick();
    str_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || str_valid !== 1'b0 || str !== 64'h0 || byte_count !== 4'd0) begin
      errors++;
      $display("FAIL hold_release: got ready=%b valid=%b str=%h count=%0d expected 1 0 0 0",
               in_ready, str_valid, str, byte_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [4];
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_byte  = seq[i];
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (str !== 64'h0 || byte_count !== 4'd0 || str_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got str=%h count=%0d valid=%b expected 0 0 0",
               str, byte_count, str_valid);
    end
    #3;
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    in_byte  = 8'h11;
    tick();
    in_byte  = 8'h00;
    tick();
    in_valid = 1'b0;
    checks++;
    if (str_valid !== 1'b1 || str !== 64'h1100000000000000 || byte_count !== 4'd1) begin
      errors++;
      $display("FAIL reset_refill: got valid=%b str=%h count=%0d expected valid=1 str=%h count=1",
               str_valid, str, byte_count, 64'h1100000000000000);
    end
    release_hold();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    flush     = 1'b0;
    str_ready = 1'b0;
    test_reset();
    test_terminator();
    test_full();
    test_first_terminator();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/string_assembler.md
STRING_ASSEMBLER -- requirements
Module: string_assembler

Interface
REQ-001 Parameter TERM_BYTE, default 8'h00, SHALL be the terminator byte value that closes a string.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 in_byte  input  8  SHALL carry the next character of the incoming stream.
REQ-005 in_valid  input  1  SHALL indicate in_byte is valid this cycle.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a byte this cycle.
REQ-007 flush  input  1  SHALL force closure of a partially filled string.
REQ-008 string  output  64  SHALL hold the packed string, first character in bits [63:56], unused bytes 8'h00.
REQ-009 str_valid  output  1  SHALL indicate string is complete and stable.
REQ-010 str_ready  input  1  SHALL indicate the downstream length stage has consumed string.
REQ-011 byte_count  output  4  SHALL hold the number of non-terminator characters stored (0..8).

Function
REQ-012 The FSM SHALL have exactly two states: FILL (in_ready=1, str_valid=0) and HOLD (in_ready=0, str_valid=1).
REQ-013 Accept SHALL occur when in_valid && in_ready; the byte SHALL be written to string[63-8*byte_count -: 8] and byte_count incremented, unless it equals TERM_BYTE.
REQ-014 An accepted TERM_BYTE SHALL not be stored or counted and SHALL move FILL->HOLD.
REQ-015 Accepting the byte that makes byte_count 8 SHALL move FILL->HOLD.
REQ-016 str_valid SHALL assert the cycle after the closing accept; latency from final accept to str_valid is 1 cycle.
REQ-017 flush in FILL with byte_count>0 and no accept SHALL move FILL->HOLD with contents unchanged.
REQ-018 flush in FILL with byte_count==0 and no accept SHALL be ignored.
REQ-019 flush coincident with an accept SHALL store the byte per REQ-013 and then move to HOLD.
REQ-020 flush in HOLD SHALL be ignored.
REQ-021 In HOLD, string and byte_count SHALL remain stable until str_ready is sampled high.
REQ-022 In HOLD with str_ready high, the next state SHALL be FILL, with string cleared to 0 and byte_count cleared to 0.
REQ-023 in_valid in HOLD SHALL be ignored; there is no same-cycle bypass from a str_ready release to a byte accept.
REQ-024 str_ready in FILL SHALL be ignored.
REQ-025 byte_count SHALL never exceed 8 and SHALL not wrap.

Reset
REQ-026 Asserting rst SHALL immediately set state=FILL, string=0, byte_count=0, str_valid=0 and in_ready=1 (after reset release), independent of clk.
REQ-027 rst mid-fill or in HOLD SHALL discard the partial or complete string; the next accepted byte SHALL land in [63:56].

Structure
REQ-028 A shared package SHALL hold STR_BYTES=8, STR_W=64, LEN_W=4 and the FILL/HOLD state encoding, for reuse by length_finder.
REQ-029 The block SHALL have no sub-module; the FSM, byte counter and byte-lane write decode SHALL be inline.

Verification
REQ-030 Bytes AA,BB,CC,DD,EE,FF,AA,00 on consecutive cycles -> string=64'hAABBCCDDEEFFAA00, byte_count=7, str_valid high 1 cycle after the 00 accept.
REQ-031 Bytes AA,BB,CC,DD,EE,FF,AA,99 -> string=64'hAABBCCDDEEFFAA99, byte_count=8, in_ready low the cycle after the 8th byte.
REQ-032 First byte 00 -> string=0, byte_count=0, str_valid=1.
REQ-033 Bytes 44,BB,CC, then flush -> string=64'h44BBCC0000000000, byte_count=3; a flush with byte_count 0 -> no str_valid.
REQ-034 HOLD with str_ready low for 5 cycles and in_valid high -> string unchanged and no byte accepted; then str_ready=1 -> FILL next cycle with string=0.
REQ-035 rst pulsed after 4 bytes -> outputs zero immediately; then bytes 11,00 -> string=64'h1100000000000000, byte_count=1.
